// File: rtl/conv1d_mac_scheduler_pkg.sv
// Shared default widths and the scheduler state encoding for the conv1d MAC scheduler.
package conv1d_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_NUM_MAC = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    TAIL,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/conv1d_mac_scheduler_if.sv
// Control, memory, MAC-array and result signals of the conv1d scheduler.
// The master modport is the scheduler side; slave is the surrounding environment.
interface conv1d_mac_scheduler_if
  import conv1d_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int NUM_MAC = DEF_NUM_MAC
);
  logic                       start;
  logic                       busy;
  logic                       done;
  logic [7:0]                 x_addr;
  logic [DATA_W-1:0]          x_rdata;
  logic [3:0]                 w_addr;
  logic [NUM_MAC*DATA_W-1:0]  w_rdata;
  logic                       mac_clear;
  logic                       mac_valid;
  logic [DATA_W-1:0]          mac_x;
  logic [NUM_MAC*DATA_W-1:0]  mac_w;
  logic [NUM_MAC*ACC_W-1:0]   mac_psum;
  logic                       res_valid;
  logic                       res_ready;
  logic [NUM_MAC*ACC_W-1:0]   res_data;
  logic [7:0]                 res_idx;

  modport master (
    input  start, x_rdata, w_rdata, mac_psum, res_ready,
    output busy, done, x_addr, w_addr, mac_clear, mac_valid, mac_x, mac_w,
           res_valid, res_data, res_idx
  );

  modport slave (
    output start, x_rdata, w_rdata, mac_psum, res_ready,
    input  busy, done, x_addr, w_addr, mac_clear, mac_valid, mac_x, mac_w,
           res_valid, res_data, res_idx
  );
endinterface

// File: rtl/conv1d_addr_gen.sv
// Output-position (p) and tap (k) counters; x_addr = p+k, w_addr = k, combinational from the counters.
module conv1d_addr_gen #(
  parameter int KERNEL_LEN = 5,
  parameter int IN_LEN     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p_clr,
  input  logic       p_inc,
  input  logic       k_clr,
  input  logic       k_inc,
  output logic [7:0] p,
  output logic [7:0] x_addr,
  output logic [3:0] w_addr,
  output logic       last_k,
  output logic       last_p
);
  localparam logic [7:0] P_LAST = 8'(IN_LEN - KERNEL_LEN);
  localparam logic [3:0] K_LAST = 4'(KERNEL_LEN - 1);

  logic [3:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (p_clr) begin
      p <= '0;
    end else if (p_inc) begin
      p <= p + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (k_clr) begin
      k <= '0;
    end else if (k_inc) begin
      k <= k + 4'd1;
    end
  end

  assign x_addr = p + {4'd0, k};
  assign w_addr = k;
  assign last_k = (k == K_LAST);
  assign last_p = (p == P_LAST);
endmodule

// File: rtl/conv1d_mac_scheduler.sv
// Drives a conv1d MAC array per output position: CLR, KERNEL_LEN issue cycles, TAIL, WAIT, OUT (>= KERNEL_LEN+4 cycles).
// res_ready low parks the FSM in OUT with res_data/res_idx held and the MAC array idle.
module conv1d_mac_scheduler
  import conv1d_pkg::*;
#(
  parameter int KERNEL_LEN = 5,
  parameter int IN_LEN     = 32,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int NUM_MAC    = DEF_NUM_MAC
) (
  input logic                    clk,
  input logic                    rst_n,
  conv1d_mac_scheduler_if.master bus
);
  state_t                    state, state_nxt;
  logic                      p_clr, p_inc, k_clr, k_inc;
  logic                      last_k, last_p;
  logic [7:0]                p;
  logic [7:0]                x_addr;
  logic [3:0]                w_addr;
  logic                      issue_d;
  logic                      done_q;
  logic [NUM_MAC*ACC_W-1:0]  res_q;
  logic [7:0]                idx_q;
  logic [DATA_W-1:0]         x_gated;
  logic [NUM_MAC*DATA_W-1:0] w_gated;

  conv1d_addr_gen #(
    .KERNEL_LEN (KERNEL_LEN),
    .IN_LEN     (IN_LEN)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .p_clr  (p_clr),
    .p_inc  (p_inc),
    .k_clr  (k_clr),
    .k_inc  (k_inc),
    .p      (p),
    .x_addr (x_addr),
    .w_addr (w_addr),
    .last_k (last_k),
    .last_p (last_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    p_clr     = 1'b0;
    p_inc     = 1'b0;
    k_clr     = 1'b0;
    k_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLR;
          p_clr     = 1'b1;
          k_clr     = 1'b1;
        end
      end
      CLR: begin
        k_clr     = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (last_k) begin
          k_clr     = 1'b1;
          state_nxt = TAIL;
        end else begin
          k_inc = 1'b1;
        end
      end
      TAIL: state_nxt = WAIT;
      WAIT: state_nxt = OUT;
      OUT: begin
        if (bus.res_ready) begin
          if (last_p) begin
            p_clr     = 1'b1;
            state_nxt = IDLE;
          end else begin
            p_inc     = 1'b1;
            state_nxt = CLR;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory data returns one cycle after the address, so the MAC strobe trails the issue cycle by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_d <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      idx_q   <= '0;
    end else begin
      issue_d <= (state == RUN);
      done_q  <= (state == OUT) && bus.res_ready && last_p;
      if (state == WAIT) begin
        res_q <= bus.mac_psum;
        idx_q <= p;
      end
    end
  end

  assign x_gated = issue_d ? bus.x_rdata : {DATA_W{1'b0}};
  assign w_gated = issue_d ? bus.w_rdata : {(NUM_MAC*DATA_W){1'b0}};

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.x_addr    = x_addr;
  assign bus.w_addr    = w_addr;
  assign bus.mac_clear = (state == CLR);
  assign bus.mac_valid = issue_d;
  assign bus.mac_x     = x_gated;
  assign bus.mac_w     = w_gated;
  assign bus.res_valid = (state == OUT);
  assign bus.res_data  = res_q;
  assign bus.res_idx   = idx_q;
endmodule

// File: tb/tb_conv1d_mac_scheduler.sv
// Bench for conv1d_mac_scheduler: memory and MAC-array models around two instances (K=3/IN=6 and K=5/IN=8),
// with a scoreboard of reference convolution results checked as each result word appears.
module tb_conv1d_mac_scheduler;

  typedef struct {
    logic [7:0]  idx;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  conv1d_mac_scheduler_if #(.DATA_W(8), .ACC_W(16), .NUM_MAC(4)) ifa ();
  conv1d_mac_scheduler_if #(.DATA_W(8), .ACC_W(16), .NUM_MAC(4)) ifb ();

  conv1d_mac_scheduler #(
    .KERNEL_LEN (3), .IN_LEN (6), .DATA_W (8), .ACC_W (16), .NUM_MAC (4)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  conv1d_mac_scheduler #(
    .KERNEL_LEN (5), .IN_LEN (8), .DATA_W (8), .ACC_W (16), .NUM_MAC (4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  logic [7:0]  xa [256];
  logic [7:0]  xb [256];
  logic [31:0] wa [16];
  logic [31:0] wb [16];
  exp_t        sb_a [$];
  exp_t        sb_b [$];
  int          total = 0;
  int          bad = 0;
  int          done_c [2];
  int          clr_c  [2];
  int          vcnt   [2];
  int          hold_c [2];
  int          ovl = 0;
  logic [63:0] nxa, nxb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mul8(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] r;
    r = 16'(a) * 16'(b);
    return r;
  endfunction

  // Direct convolution reference, wrapping each kernel sum to 16 bits.
  function automatic logic [63:0] ref_res(input bit b, input int p);
    logic [63:0] r;
    logic [15:0] acc;
    int          kl;
    kl = b ? 5 : 3;
    r  = '0;
    for (int n = 0; n < 4; n++) begin
      acc = '0;
      for (int k = 0; k < kl; k++) begin
        if (b) acc = acc + mul8(xb[p+k], wb[k][n*8 +: 8]);
        else   acc = acc + mul8(xa[p+k], wa[k][n*8 +: 8]);
      end
      r[n*16 +: 16] = acc;
    end
    return r;
  endfunction

  // Synchronous memories and MAC arrays.
  initial begin
    ifa.x_rdata = '0; ifa.w_rdata = '0; ifa.mac_psum = '0;
    ifb.x_rdata = '0; ifb.w_rdata = '0; ifb.mac_psum = '0;
    forever begin
      @(posedge clk);
      ifa.x_rdata <= xa[ifa.x_addr];
      ifa.w_rdata <= wa[ifa.w_addr];
      ifb.x_rdata <= xb[ifb.x_addr];
      ifb.w_rdata <= wb[ifb.w_addr];
      nxa = ifa.mac_psum;
      nxb = ifb.mac_psum;
      for (int n = 0; n < 4; n++) begin
        if (ifa.mac_clear) nxa[n*16 +: 16] = '0;
        else if (ifa.mac_valid) nxa[n*16 +: 16] = nxa[n*16 +: 16] + mul8(ifa.mac_x, ifa.mac_w[n*8 +: 8]);
        if (ifb.mac_clear) nxb[n*16 +: 16] = '0;
        else if (ifb.mac_valid) nxb[n*16 +: 16] = nxb[n*16 +: 16] + mul8(ifb.mac_x, ifb.mac_w[n*8 +: 8]);
      end
      ifa.mac_psum <= nxa;
      ifb.mac_psum <= nxb;
    end
  end

  // Monitor for instance A.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifa.mac_clear && ifa.mac_valid) ovl++;
        if (ifa.mac_clear) begin clr_c[0]++; vcnt[0] = 0; end
        if (ifa.mac_valid) vcnt[0]++;
        if (ifa.done) begin
          done_c[0]++;
          chk("a_busy_at_done", 64'(ifa.busy), 64'd0);
        end
        if (ifa.res_valid) begin
          if (sb_a.size() == 0) begin
            chk("a_unexpected_result", 64'(sb_a.size()), 64'd1);
          end else begin
            chk("a_res_data", ifa.res_data, sb_a[0].data);
            chk("a_res_idx", 64'(ifa.res_idx), 64'(sb_a[0].idx));
            if (ifa.res_ready) begin
              chk("a_mac_valid_cnt", 64'(vcnt[0]), 64'd3);
              void'(sb_a.pop_front());
            end else begin
              hold_c[0]++;
            end
          end
        end
      end
    end
  end

  // Monitor for instance B.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifb.mac_clear && ifb.mac_valid) ovl++;
        if (ifb.mac_clear) begin clr_c[1]++; vcnt[1] = 0; end
        if (ifb.mac_valid) vcnt[1]++;
        if (ifb.done) done_c[1]++;
        if (ifb.res_valid) begin
          if (sb_b.size() == 0) begin
            chk("b_unexpected_result", 64'(sb_b.size()), 64'd1);
          end else begin
            chk("b_res_data", ifb.res_data, sb_b[0].data);
            chk("b_res_idx", 64'(ifb.res_idx), 64'(sb_b[0].idx));
            if (ifb.res_ready) begin
              chk("b_mac_valid_cnt", 64'(vcnt[1]), 64'd5);
              void'(sb_b.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic zero_chk(input string tag, input logic [63:0] ctl, input logic [63:0] w, input logic [63:0] d);
    chk({tag, "_ctl"}, ctl, 64'd0);
    chk({tag, "_macw"}, w, 64'd0);
    chk({tag, "_res"}, d, 64'd0);
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic run_frame(input bit b, input bit mid_start);
    int d0, c0, t;
    for (int p = 0; p < 4; p++) begin
      if (b) sb_b.push_back('{8'(p), ref_res(1'b1, p)});
      else   sb_a.push_back('{8'(p), ref_res(1'b0, p)});
    end
    d0 = done_c[b];
    c0 = clr_c[b];
    pulse_start(b);
    chk(b ? "b_busy_after_start" : "a_busy_after_start", 64'(b ? ifb.busy : ifa.busy), 64'd1);
    if (mid_start) begin
      t = 0;
      while (!(b ? ifb.mac_valid : ifa.mac_valid) && t < 100) begin @(posedge clk); #1; t++; end
      chk("mid_start_wait", 64'(t < 100), 64'd1);
      pulse_start(b);
    end
    t = 0;
    while (done_c[b] == d0 && t < 400) begin @(posedge clk); #1; t++; end
    chk(b ? "b_done_wait" : "a_done_wait", 64'(t < 400), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk(b ? "b_done_cnt" : "a_done_cnt", 64'(done_c[b] - d0), 64'd1);
    chk(b ? "b_clear_cnt" : "a_clear_cnt", 64'(clr_c[b] - c0), 64'd4);
    chk(b ? "b_sb_left" : "a_sb_left", 64'(b ? sb_b.size() : sb_a.size()), 64'd0);
    chk(b ? "b_busy_end" : "a_busy_end", 64'(b ? ifb.busy : ifa.busy), 64'd0);
  endtask

  task automatic ready_drv();
    int t;
    t = 0;
    while (!(ifa.res_valid && ifa.res_idx == 8'd0) && t < 200) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    ifa.res_ready = 1'b0;
    t = 0;
    while (!ifa.res_valid && t < 200) begin @(posedge clk); #1; t++; end
    chk("hold_wait", 64'(t < 200), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    ifa.res_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, d0, t;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.res_ready = 1'b1;
    ifb.start = 1'b0; ifb.res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin done_c[i] = 0; clr_c[i] = 0; vcnt[i] = 0; hold_c[i] = 0; end
    for (int i = 0; i < 256; i++) begin xa[i] = '0; xb[i] = '0; end
    for (int i = 0; i < 16; i++) begin wa[i] = '0; wb[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    zero_chk("a_reset", 64'({ifa.busy, ifa.done, ifa.res_valid, ifa.mac_clear, ifa.mac_valid,
                             ifa.x_addr, ifa.w_addr, ifa.res_idx, ifa.mac_x}), 64'(ifa.mac_w), ifa.res_data);
    zero_chk("b_reset", 64'({ifb.busy, ifb.done, ifb.res_valid, ifb.mac_clear, ifb.mac_valid,
                             ifb.x_addr, ifb.w_addr, ifb.res_idx, ifb.mac_x}), 64'(ifb.mac_w), ifb.res_data);
    rst_n = 1'b1;

    // x = 1..6, all weights 1; a start pulse during RUN is ignored.
    for (int i = 0; i < 6; i++) xa[i] = 8'(i + 1);
    for (int k = 0; k < 3; k++) wa[k] = 32'h0101_0101;
    run_frame(1'b0, 1'b1);

    // Kernel 2 weights -1.
    for (int k = 0; k < 3; k++) wa[k] = 32'h01FF_0101;
    run_frame(1'b0, 1'b0);

    // Backpressure: res_ready low for 5 cycles at p=1.
    for (int k = 0; k < 3; k++) wa[k] = 32'h0101_0101;
    hold_c[0] = 0;
    fork
      run_frame(1'b0, 1'b0);
      ready_drv();
    join
    chk("a_hold_cycles", 64'(hold_c[0]), 64'd5);

    // Reset during RUN of p=2: outputs clear at once, no done, restart from p=0.
    for (int p = 0; p < 4; p++) sb_a.push_back('{8'(p), ref_res(1'b0, p)});
    c0 = clr_c[0];
    d0 = done_c[0];
    pulse_start(1'b0);
    t = 0;
    while (clr_c[0] - c0 < 3 && t < 200) begin @(posedge clk); #1; t++; end
    chk("a_reach_p2", 64'(t < 200), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    zero_chk("a_midreset", 64'({ifa.busy, ifa.done, ifa.res_valid, ifa.mac_clear, ifa.mac_valid,
                                ifa.x_addr, ifa.w_addr, ifa.res_idx, ifa.mac_x}), 64'(ifa.mac_w), ifa.res_data);
    sb_a.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_no_done_abort", 64'(done_c[0] - d0), 64'd0);
    chk("a_idle_after_reset", 64'(ifa.busy), 64'd0);
    run_frame(1'b0, 1'b0);

    // K=5, all weights and samples 127: 5*16129 wraps to 15109 per kernel.
    for (int i = 0; i < 8; i++) xb[i] = 8'd127;
    for (int k = 0; k < 5; k++) wb[k] = 32'h7F7F_7F7F;
    chk("b_ref_wrap", ref_res(1'b1, 0), {4{16'd15109}});
    run_frame(1'b1, 1'b0);

    chk("clear_valid_overlap", 64'(ovl), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv1d_mac_scheduler.md
CONV1D_MAC_SCHEDULER -- requirements
Module: conv1d_mac_scheduler

Interface
REQ-001 Parameter KERNEL_LEN, default 5, taps per kernel (1..16).
REQ-002 Parameter IN_LEN, default 32, input samples per frame (KERNEL_LEN..256).
REQ-003 Parameter DATA_W, default 8, signed weight/sample width.
REQ-004 Parameter ACC_W, default 16, signed partial-sum width.
REQ-005 Parameter NUM_MAC, default 4, parallel kernels (one per MAC).
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 start  in  1  one-cycle pulse; begins a frame when idle.
REQ-009 busy  out  1  high from accepted start until done.
REQ-010 done  out  1  one-cycle pulse after last result accepted.
REQ-011 x_addr  out  8  input-sample memory read address.
REQ-012 x_rdata  in  DATA_W  sample; synchronous memory, valid 1 cycle after x_addr.
REQ-013 w_addr  out  4  weight memory read address (tap index).
REQ-014 w_rdata  in  NUM_MAC*DATA_W  weights of all kernels for tap w_addr; 1-cycle latency; kernel n in slice n.
REQ-015 mac_clear  out  1  synchronous accumulator clear to the conv_1d_multiple_mac array.
REQ-016 mac_valid  out  1  accumulate enable to the array.
REQ-017 mac_x  out  DATA_W  sample broadcast to every MAC x input.
REQ-018 mac_w  out  NUM_MAC*DATA_W  per-MAC weight; slice n drives w_in_(n+1).
REQ-019 mac_psum  in  NUM_MAC*ACC_W  registered MAC outputs out_1..out_NUM_MAC.
REQ-020 res_valid  out  1  result word valid.
REQ-021 res_ready  in  1  downstream accepts result.
REQ-022 res_data  out  NUM_MAC*ACC_W  one output position, all kernels.
REQ-023 res_idx  out  8  output position p of res_data.

Function
REQ-024 Output positions p = 0..IN_LEN-KERNEL_LEN; per p, tap k = 0..KERNEL_LEN-1 reads x_addr = p+k, w_addr = k.
REQ-025 FSM states: IDLE, CLR, RUN, TAIL, WAIT, OUT.
REQ-026 IDLE: start -> CLR with p=0, busy=1; start is ignored in every other state.
REQ-027 CLR: mac_clear=1 for exactly one cycle, mac_valid=0 -> RUN with k=0.
REQ-028 RUN: issues one address pair per cycle for KERNEL_LEN cycles; after k=KERNEL_LEN-1 -> TAIL.
REQ-029 mac_valid, mac_x, mac_w = issue strobe and memory data delayed one cycle; high on RUN cycles 2..KERNEL_LEN and in TAIL, exactly KERNEL_LEN cycles per position.
REQ-030 WAIT: one cycle, mac_valid=0, lets mac_psum settle -> OUT.
REQ-031 OUT: res_data captures mac_psum on entry, res_idx=p, res_valid=1; res_data/res_idx held stable while res_ready=0.
REQ-032 OUT with res_ready=1: p<IN_LEN-KERNEL_LEN -> CLR with p+1; else -> IDLE, done=1 for one cycle, busy=0.
REQ-033 Minimum per-position latency KERNEL_LEN+4 cycles (CLR+RUN+TAIL+WAIT+OUT).
REQ-034 Accumulation wraps mod 2^ACC_W in the MACs; scheduler passes sums unmodified, no saturation.
REQ-035 KERNEL_LEN=1: RUN lasts one cycle; IN_LEN=KERNEL_LEN: exactly one result then done.
REQ-036 mac_clear and mac_valid are never high in the same cycle.

Reset
REQ-037 rst_n low asynchronously forces IDLE, p=k=0, busy=done=res_valid=mac_clear=mac_valid=0, all address/data outputs 0.
REQ-038 Reset mid-frame abandons the frame with no done pulse; next start begins at p=0 with a CLR.

Structure
REQ-039 Package conv1d_pkg holds DATA_W, ACC_W, NUM_MAC defaults and the FSM state enumeration.
REQ-040 One sub-module conv1d_addr_gen holds the p/k counters and address generation; FSM and result register stay in the top.

Verification
REQ-041 K=3, IN_LEN=6, all weights 1, x=1..6, res_ready=1 -> 4 results, every kernel 6,9,12,15, res_idx 0..3, one done pulse.
REQ-042 Same frame, kernel 2 weights -1 -> kernel 2 slice -6,-9,-12,-15, others unchanged.
REQ-043 res_ready low 5 cycles at p=1 -> res_valid held, res_data=9 stable, no MAC activity, then resumes.
REQ-044 K=5, all w=127, x=127 -> each result 15109 (80645 wrapped mod 2^16).
REQ-045 start pulses during RUN, and rst_n low during RUN of p=2 -> start ignored; all outputs 0 immediately, no done, new start yields p=0.
REQ-046 Count mac_valid per position = KERNEL_LEN, mac_clear once before each, never overlapping.
